sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
- Sequencer for the line-buffer delay chain built from cascaded 8-bit fast FIFO cells in the Sobel datapath.
- Accepts a raster pixel stream and drives the shared FIFO Enable so all cells shift together, once per accepted pixel.
- Tracks row and column and flags when the 3x3 window at the FIFO taps is fully inside the image.
- Reports the window centre coordinate and signals frame completion.

Parameters:
IMG_WIDTH, 8, pixels per row (>=3); line-buffer depth matches this value
IMG_HEIGHT, 6, rows per frame (>=3)
CNT_W, 9, width of row/column counters; must hold max(IMG_WIDTH, IMG_HEIGHT)-1

Ports:
CLK  input  1  clock, all logic on rising edge
Reset  input  1  synchronous, active-high; the clock and reset are the block's only clock/reset, reset is synchronous and active-high
Start  input  1  one-cycle request to begin a frame; honoured only in IDLE
Abort  input  1  cancel current frame; synchronous
PixelValid  input  1  source presents a pixel on the datapath DataIn this cycle
Ready  output  1  controller will accept a pixel this cycle
Fifo_Enable  output  1  shift enable to every FIFO cell in the line-buffer chain
Window_Valid  output  1  FIFO taps hold a complete in-image 3x3 window
Win_Row  output  CNT_W  row of window centre, valid with Window_Valid
Win_Col  output  CNT_W  column of window centre, valid with Window_Valid
Frame_Done  output  1  one-cycle pulse after last pixel accepted
Busy  output  1  high in PRIME or STREAM

Behaviour:
- States: IDLE, PRIME, STREAM, DONE; 2-bit encoding.
- Reset (any state, mid-frame included) forces the following on the next edge:
  - state IDLE;
  - row and col counters 0;
  - Window_Valid, Frame_Done, Win_Row, Win_Col 0.
- Ready and Busy are 0 in IDLE, so they are also 0 after reset.
- Ready is combinational: 1 iff state is PRIME or STREAM.
- Fifo_Enable is combinational: Ready & PixelValid. It is the accept strobe, asserted in the same cycle as the data.
- IDLE -> PRIME when Start=1. Counters are cleared at this transition. PixelValid in IDLE is ignored; Fifo_Enable stays 0.
- On each accept:
  - col increments;
  - at col=IMG_WIDTH-1, col wraps to 0 and row increments.
- PRIME -> STREAM on the accept of pixel index 2*IMG_WIDTH+2, i.e. row=2, col=2. This is the first full window.
- In STREAM, the accept of row=IMG_HEIGHT-1, col=IMG_WIDTH-1 moves the state to DONE.
- DONE lasts exactly one cycle:
  - Frame_Done=1 in that cycle;
  - then IDLE;
  - Ready=0 in DONE.
- Window_Valid is registered. It is 1 in cycle N+1 iff the pixel accepted in cycle N had row>=2 and col>=2; otherwise 0. The one-cycle latency matches the FIFO shift, so taps and flag align.
- Win_Row and Win_Col are registered with Window_Valid: row-1 and col-1 of that accepted pixel. They hold their last value when Window_Valid=0.
- Bubbles: PixelValid=0 leaves counters frozen, Fifo_Enable=0, and Window_Valid=0 the next cycle. The FIFO contents are held because Enable is low.
- Edge columns (col<2) produce no Window_Valid. The FIFO still shifts, so the chain carries data across row wrap.
- Window count per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Abort:
  - in PRIME or STREAM: go to IDLE next edge, clear counters, clear Window_Valid, no Frame_Done;
  - Abort has priority over a simultaneous accept, so Fifo_Enable=0 in that cycle;
  - in IDLE or DONE, Abort is ignored.
- Start while not in IDLE is ignored.
- Reset has priority over Abort and Start.
- Counters never exceed IMG_WIDTH-1 and IMG_HEIGHT-1; no wrap beyond the frame.

Test Plan:
- Reset check: Reset=1 for 2 cycles, then stimulus idle -> Ready=0, Busy=0, Window_Valid=0, Frame_Done=0, Win_Row=Win_Col=0; PixelValid=1 in IDLE gives Fifo_Enable=0.
- Full frame, defaults (8x6), Start then PixelValid held 1:
  - Fifo_Enable high for exactly 48 cycles;
  - first Window_Valid one cycle after the 19th accept (index 18), with Win_Row=1, Win_Col=1;
  - 24 Window_Valid pulses total;
  - last pulse has Win_Row=4, Win_Col=6;
  - Frame_Done single pulse the cycle after the 48th accept, then Ready=0.
- Bubbles: same frame with PixelValid toggling 1,0 -> 48 accepts over 96 cycles, still 24 windows with identical coordinates, Window_Valid never high after a 0-PixelValid cycle.
- Abort at 30th accept -> that pixel not accepted, IDLE next cycle, no Frame_Done; new Start then yields a full correct frame (24 windows, first at Win_Row=1, Win_Col=1).
- Reset mid-STREAM (after 25 accepts) -> next cycle IDLE, all outputs 0; Start during PRIME or STREAM is ignored (counters continue unperturbed).
- Row-wrap check: at accepts with col=0 or col=1 in rows >=2 -> Window_Valid=0 next cycle; col=2 -> Window_Valid=1, Win_Col=1.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// Raster sequencer for the Sobel line-buffer FIFO chain: shifts every cell once per accepted
// pixel and flags, with centre coordinates, when the taps hold a full in-image 3x3 window.
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 6,
  parameter int CNT_W      = 9
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic             PixelValid,
  output logic             Ready,
  output logic             Fifo_Enable,
  output logic             Window_Valid,
  output logic [CNT_W-1:0] Win_Row,
  output logic [CNT_W-1:0] Win_Col,
  output logic             Frame_Done,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_win_vld_p1;
  logic [CNT_W-1:0] r_win_row_p1;
  logic [CNT_W-1:0] r_win_col_p1;

  logic w_active;
  logic w_accept;
  logic w_abort;
  logic w_col_last;
  logic w_row_last;
  logic w_last_pix;
  logic w_first_win;
  logic w_win_hit;

  // Abort outranks a simultaneous pixel, so the FIFO chain never shifts on an aborted cycle.
  assign w_active    = (r_state == S_PRIME) || (r_state == S_STREAM);
  assign w_abort     = w_active & Abort;
  assign w_accept    = w_active & PixelValid & ~Abort;
  assign w_col_last  = (r_col == COL_MAX);
  assign w_row_last  = (r_row == ROW_MAX);
  assign w_last_pix  = w_col_last & w_row_last;
  assign w_first_win = (r_row == TWO) && (r_col == TWO);
  assign w_win_hit   = (r_row >= TWO) && (r_col >= TWO);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_state_nxt = S_PRIME;
      S_PRIME: begin
        if (Abort)                       w_state_nxt = S_IDLE;
        else if (w_accept && w_last_pix)  w_state_nxt = S_DONE;
        else if (w_accept && w_first_win) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (Abort)                       w_state_nxt = S_IDLE;
        else if (w_accept && w_last_pix) w_state_nxt = S_DONE;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Ready        = w_active;
    Busy         = w_active;
    Fifo_Enable  = w_accept;
    Frame_Done   = (r_state == S_DONE);
    Window_Valid = r_win_vld_p1;
    Win_Row      = r_win_row_p1;
    Win_Col      = r_win_col_p1;
  end

  // Raster position of the next pixel; the row holds at the last line so it never leaves the frame.
  always_ff @(posedge CLK) begin
    if (Reset || w_abort || ((r_state == S_IDLE) && Start)) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        if (!w_row_last) r_row <= r_row + ONE;
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

  // Stage p1: aligned with the FIFO shift, so the flag and centre match the taps.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_win_vld_p1 <= 1'b0;
      r_win_row_p1 <= '0;
      r_win_col_p1 <= '0;
    end else begin
      r_win_vld_p1 <= w_accept & w_win_hit;
      if (w_accept && w_win_hit) begin
        r_win_row_p1 <= r_row - ONE;
        r_win_col_p1 <= r_col - ONE;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl at the default 8x6 geometry.
module tb_sobel_window_ctrl;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic       PixelValid = 1'b0;
  logic       Ready, Fifo_Enable, Window_Valid, Frame_Done, Busy;
  logic [8:0] Win_Row, Win_Col;

  int tests = 0;
  int fails = 0;

  int acc, wvn, fdn, first_acc, bubble_err;
  int first_r, first_c, last_r, last_c;

  sobel_window_ctrl #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .CNT_W(9)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Abort(Abort), .PixelValid(PixelValid),
    .Ready(Ready), .Fifo_Enable(Fifo_Enable), .Window_Valid(Window_Valid),
    .Win_Row(Win_Row), .Win_Col(Win_Col), .Frame_Done(Frame_Done), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: PixelValid held high; mode 1: PixelValid toggles 1,0.
  // stop_at > 0 returns just before the accept with that many accepts done.
  // poke drives Start while mid-frame, which must have no effect.
  task automatic frame(input int mode, input int stop_at, input bit poke);
    logic [8:0] mrow, mcol, er, ec;
    bit exp_wv, pv, prev_pv;
    int post;
    acc = 0; wvn = 0; fdn = 0; first_acc = -1; bubble_err = 0;
    first_r = -1; first_c = -1; last_r = -1; last_c = -1;
    mrow = 0; mcol = 0; er = 0; ec = 0; exp_wv = 0; prev_pv = 0; post = 0;
    Start = 1'b1; PixelValid = 1'b0;
    tick();
    Start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stop_at > 0 && acc == stop_at) break;
      pv = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      PixelValid = pv;
      Start = poke && (acc == 5 || acc == 22);
      #1;
      chk("fifo_en", Fifo_Enable, (acc < 48) && pv);
      chk("ready", Ready, acc < 48);
      chk("busy", Busy, acc < 48);
      chk("win_valid", Window_Valid, exp_wv);
      if (exp_wv) begin
        chk("win_row", Win_Row, er);
        chk("win_col", Win_Col, ec);
      end
      chk("frame_done", Frame_Done, post == 1);
      if (Window_Valid) begin
        wvn++;
        if (wvn == 1) begin first_acc = acc; first_r = Win_Row; first_c = Win_Col; end
        last_r = Win_Row; last_c = Win_Col;
      end
      if (Frame_Done) fdn++;
      if (!prev_pv && Window_Valid) bubble_err++;
      if (acc < 48 && pv) begin
        exp_wv = (mrow >= 2) && (mcol >= 2);
        er = mrow - 9'd1;
        ec = mcol - 9'd1;
        if (mcol == 9'd7) begin mcol = 0; mrow++; end
        else mcol++;
        acc++;
      end else begin
        exp_wv = 0;
      end
      prev_pv = pv;
      if (acc == 48) post++;
      if (post == 4) break;
      tick();
    end
    Start = 1'b0;
  endtask

  initial begin
    // Reset for two cycles, then idle outputs
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_ready", Ready, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_wv", Window_Valid, 0);
    chk("rst_fd", Frame_Done, 0);
    chk("rst_row", Win_Row, 0);
    chk("rst_col", Win_Col, 0);
    PixelValid = 1'b1;
    #1;
    chk("idle_fifo_en", Fifo_Enable, 0);
    tick();
    chk("idle_wv", Window_Valid, 0);
    chk("idle_ready", Ready, 0);
    PixelValid = 1'b0;

    // Full frame, continuous pixels
    frame(0, 0, 0);
    chk("full_accepts", acc, 48);
    chk("full_windows", wvn, 24);
    chk("full_first_at", first_acc, 19);
    chk("full_first_row", first_r, 1);
    chk("full_first_col", first_c, 1);
    chk("full_last_row", last_r, 4);
    chk("full_last_col", last_c, 6);
    chk("full_done_cnt", fdn, 1);
    chk("full_end_ready", Ready, 0);

    // Same frame with bubbles on every other cycle
    frame(1, 0, 0);
    chk("bub_accepts", acc, 48);
    chk("bub_windows", wvn, 24);
    chk("bub_first_row", first_r, 1);
    chk("bub_first_col", first_c, 1);
    chk("bub_last_row", last_r, 4);
    chk("bub_last_col", last_c, 6);
    chk("bub_after_gap", bubble_err, 0);
    chk("bub_done_cnt", fdn, 1);

    // Abort on the 30th accept
    frame(0, 29, 0);
    Abort = 1'b1; PixelValid = 1'b1;
    #1;
    chk("abort_fifo_en", Fifo_Enable, 0);
    tick();
    Abort = 1'b0; PixelValid = 1'b0;
    #1;
    chk("abort_ready", Ready, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_fd", Frame_Done, 0);
    chk("abort_wv", Window_Valid, 0);
    tick();
    chk("abort_fd2", Frame_Done, 0);
    frame(0, 0, 0);
    chk("reframe_windows", wvn, 24);
    chk("reframe_first_row", first_r, 1);
    chk("reframe_first_col", first_c, 1);
    chk("reframe_done_cnt", fdn, 1);

    // Reset after 25 accepts, with Start poked in PRIME and STREAM beforehand
    frame(0, 25, 1);
    chk("poke_accepts", acc, 25);
    Reset = 1'b1; PixelValid = 1'b1;
    tick();
    chk("mrst_ready", Ready, 0);
    chk("mrst_busy", Busy, 0);
    chk("mrst_fifo_en", Fifo_Enable, 0);
    chk("mrst_wv", Window_Valid, 0);
    chk("mrst_fd", Frame_Done, 0);
    chk("mrst_row", Win_Row, 0);
    chk("mrst_col", Win_Col, 0);
    Reset = 1'b0; PixelValid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
